// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared types and constants for the gate sweep sequencer.
//   state_t       - sequencer state encoding (IDLE, DRIVE, SAMPLE, DONE)
//   tt_width()    - truth-table width for a given input count (2**n)
//   cnt_width()   - settle counter width, clog2(settle) with a floor of 1
//   TT_AND2/OR2   - golden truth tables for 2-input AND / OR gates
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

  function automatic int cnt_width(input int settle);
    return ($clog2(settle) < 1) ? 1 : $clog2(settle);
  endfunction

  localparam logic [3:0] TT_AND2 = 4'b1000;
  localparam logic [3:0] TT_OR2  = 4'b1110;

endpackage

// File: rtl/gate_sweep_ctrl_settle_counter.sv
// settle_counter: loadable down-counter that saturates at zero.
//   clk, rst_n - clock, synchronous active-low reset (count -> 0)
//   load       - load load_val this cycle (takes priority over counting)
//   load_val   - value to load
//   zero       - count is zero
module settle_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: walks a combinational gate through every input vector,
// waits SETTLE_CYCLES per vector, captures the output into a truth table and
// compares it against expected_tt.
//
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start        - one-cycle sweep request
//   expected_tt  - golden truth table, bit i = expected output for vector i
//   gate_in      - vector driven to the gate (registered)
//   gate_out     - gate output under test
//   busy         - high in DRIVE and SAMPLE
//   done         - one-cycle strobe, high during the DONE cycle
//   pass         - last table matched expected_tt
//   truth_table  - last captured table
//   first_fail   - lowest mismatching vector of last sweep (0 on pass)
//   dbg_state    - current sequencer state
//
// Handshake: start is a request without backpressure; it is accepted only in
// IDLE and dropped otherwise (no queuing). done is a strobe with no ready;
// truth_table/pass/first_fail are valid from the done cycle and hold until
// the next done.
//
// Optional feature: define GATE_SWEEP_AUTO_REPEAT_EN to make DONE restart a
// new sweep immediately instead of returning to IDLE.
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [(1<<N_IN)-1:0]      expected_tt,
  output logic [N_IN-1:0]           gate_in,
  input  logic                      gate_out,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [(1<<N_IN)-1:0]      truth_table,
  output logic [N_IN-1:0]           first_fail,
  output state_t                    dbg_state
);

  localparam int TT_W  = tt_width(N_IN);
  localparam int CNT_W = cnt_width(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [N_IN-1:0]  LAST_IDX    = N_IN'(TT_W - 1);

  if (N_IN < 1 || N_IN > 4) begin : g_bad_n_in
    $error("gate_sweep_ctrl: N_IN must be 1..4");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("gate_sweep_ctrl: SETTLE_CYCLES must be >= 1");
  end

  state_t            state;
  logic [N_IN-1:0]   idx;
  logic [TT_W-1:0]   work_tt;
  logic [TT_W-1:0]   final_tt;
  logic [N_IN-1:0]   fail_idx;
  logic              cnt_load;
  logic              cnt_zero;

  assign dbg_state = state;

  // Table including the bit being sampled this cycle. The results are
  // registered on the SAMPLE->DONE edge from this so they are already
  // valid while done is high.
  always_comb begin
    final_tt      = work_tt;
    final_tt[idx] = gate_out;
  end

  // Fixed-priority search: scanning downward lets the lowest index win.
  always_comb begin
    fail_idx = '0;
    for (int i = TT_W - 1; i >= 0; i--) begin
      if (final_tt[i] != expected_tt[i]) fail_idx = N_IN'(i);
    end
  end

  // Reload the settle counter on every entry into DRIVE.
  always_comb begin
    cnt_load = 1'b0;
    case (state)
      IDLE:    cnt_load = start;
      SAMPLE:  cnt_load = (idx != LAST_IDX);
`ifdef GATE_SWEEP_AUTO_REPEAT_EN
      DONE:    cnt_load = 1'b1;
`endif
      default: cnt_load = 1'b0;
    endcase
  end

  settle_counter #(.W(CNT_W)) u_settle (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (SETTLE_LOAD),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      work_tt     <= '0;
      gate_in     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      truth_table <= '0;
      first_fail  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state   <= DRIVE;
            idx     <= '0;
            work_tt <= '0;
            gate_in <= '0;
            busy    <= 1'b1;
          end
        end
        DRIVE: begin
          if (cnt_zero) state <= SAMPLE;
        end
        SAMPLE: begin
          work_tt <= final_tt;
          if (idx == LAST_IDX) begin
            state       <= DONE;
            busy        <= 1'b0;
            gate_in     <= '0;
            done        <= 1'b1;
            truth_table <= final_tt;
            pass        <= (final_tt == expected_tt);
            first_fail  <= fail_idx;
          end else begin
            state   <= DRIVE;
            idx     <= idx + 1'b1;
            gate_in <= idx + 1'b1;
          end
        end
        DONE: begin
`ifdef GATE_SWEEP_AUTO_REPEAT_EN
          state   <= DRIVE;
          idx     <= '0;
          work_tt <= '0;
          gate_in <= '0;
          busy    <= 1'b1;
`else
          state   <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Testbench for gate_sweep_ctrl: a behavioural gate (truth-table lookup)
// drives gate_out; expected results come from a direct truth-table model.
module tb_gate_sweep_ctrl;
  import gate_sweep_pkg::*;

  localparam int N_IN   = 2;
  localparam int SETTLE = 4;
  localparam int TT_W   = 1 << N_IN;
  localparam int LAT    = TT_W * (SETTLE + 1) + 1;
  localparam int EXP_W  = N_IN + 1 + TT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic            start;
  logic [TT_W-1:0] expected_tt;
  logic [N_IN-1:0] gate_in;
  logic            gate_out;
  logic            busy, done, pass;
  logic [TT_W-1:0] truth_table;
  logic [N_IN-1:0] first_fail;
  state_t          dbg_state;

  // Gate under test: arbitrary function given as a truth table.
  logic [TT_W-1:0] gate_tt;
  assign gate_out = gate_tt[gate_in];

  gate_sweep_ctrl #(.N_IN(N_IN), .SETTLE_CYCLES(SETTLE)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .expected_tt (expected_tt),
    .gate_in     (gate_in),
    .gate_out    (gate_out),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .truth_table (truth_table),
    .first_fail  (first_fail),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [EXP_W-1:0] exp_q[$];
  int               lat_q[$];
  logic             auto_run = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the sweep captures the gate's own truth table; compare bitwise.
  function automatic logic [EXP_W-1:0] model(input logic [TT_W-1:0] g, input logic [TT_W-1:0] e);
    logic [N_IN-1:0] ff = '0;
    logic found = 1'b0;
    for (int i = 0; i < TT_W; i++) begin
      if (!found && g[i] != e[i]) begin
        ff = N_IN'(i);
        found = 1'b1;
      end
    end
    return {ff, (g == e), g};
  endfunction

  // Monitor: pops an expectation on every done strobe.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
      end else begin
        logic [EXP_W-1:0] e;
        int l;
        e = exp_q.pop_front();
        l = lat_q.pop_front();
        check("truth_table", 32'(truth_table), 32'(e[TT_W-1:0]));
        check("pass", 32'(pass), 32'(e[TT_W]));
        check("first_fail", 32'(first_fail), 32'(e[EXP_W-1 -: N_IN]));
        check("done_latency", cyc, l);
      end
    end
    if (rst_n && auto_run) check("busy_vs_done", 32'(busy), 32'(!done));
  end

  // ---------------- driver tasks ----------------
  task automatic issue_start(input int n_sweeps);
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= n_sweeps; k++) begin
      exp_q.push_back(model(gate_tt, expected_tt));
      lat_q.push_back(cyc + k * LAT);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < LAT * 4 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got %0d pending sweeps expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
    check({tag, "_pass"}, 32'(pass), 0);
    check({tag, "_truth_table"}, 32'(truth_table), 0);
    check({tag, "_first_fail"}, 32'(first_fail), 0);
    check({tag, "_gate_in"}, 32'(gate_in), 0);
    check({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
  endtask

  task automatic run_sweep(input logic [TT_W-1:0] g, input logic [TT_W-1:0] e);
    gate_tt     = g;
    expected_tt = e;
    issue_start(1);
    wait_idle();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    gate_tt     = '0;
    expected_tt = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

`ifdef GATE_SWEEP_AUTO_REPEAT_EN
    gate_tt     = TT_AND2;
    expected_tt = TT_AND2;
    issue_start(3);
    auto_run = 1'b1;
    wait_idle();
    auto_run = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("auto_stop");
    rst_n = 1'b1;
`else
    // Directed cases: AND passes, OR and stuck-0 fail at known rows.
    run_sweep(TT_AND2, TT_AND2);
    run_sweep(TT_OR2, TT_AND2);
    run_sweep(4'b0000, TT_AND2);

    // Results hold across IDLE.
    repeat (5) @(negedge clk);
    check("hold_truth_table", 32'(truth_table), 0);
    check("hold_first_fail", 32'(first_fail), 3);

    // start pulses during a sweep are ignored.
    gate_tt     = TT_AND2;
    expected_tt = TT_AND2;
    issue_start(1);
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (LAT + 5) @(negedge clk);

    // Reset during SAMPLE of vector 2 discards the sweep.
    gate_tt     = TT_OR2;
    expected_tt = TT_OR2;
    issue_start(1);
    begin
      int n = 0;
      while (!(dbg_state == SAMPLE && gate_in == 2) && n < LAT * 2) begin
        @(negedge clk);
        n++;
      end
      check("reach_sample_idx2", 32'(n < LAT * 2), 1);
    end
    rst_n = 1'b0;
    exp_q.delete();
    lat_q.delete();
    @(negedge clk);
    check_reset_outputs("mid_reset");
    rst_n = 1'b1;
    run_sweep(TT_OR2, TT_AND2);

    // Randomized sweeps.
    for (int t = 0; t < 8; t++) begin
      logic [TT_W-1:0] g;
      logic [TT_W-1:0] e;
      g = TT_W'($urandom_range(0, (1 << TT_W) - 1));
      e = ($urandom_range(0, 1) == 1) ? g : TT_W'($urandom_range(0, (1 << TT_W) - 1));
      run_sweep(g, e);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
`endif

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
